vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Downstream consumer of the VGA timing generator's hsync, vsync, xaddr, yaddr and addr_valid outputs.
- Renders an 80x30 character text mode: fetches the character/attribute word from an external text RAM, then the glyph row from an external font ROM, then drives 12-bit RGB.
- Sync signals are delayed to stay aligned with the pixel data.
- Adds attribute blink and a hardware cursor driven by a frame counter.

Parameters:
- PIXEL_WIDTH, 640, visible width in pixels.
- PIXEL_HEIGHT, 480, visible height in pixels.
- CHAR_W, 8, glyph width in pixels (fixed 8; font_data width).
- CHAR_H, 16, glyph height in pixels (power of 2).
- BLINK_FRAMES, 32, frames per blink half-period (power of 2).

Ports:
- pxclk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- hsync_in  in  1  from timing generator.
- vsync_in  in  1  from timing generator, active-high pulse.
- xaddr  in  $clog2(PIXEL_WIDTH)  pixel column within the visible region.
- yaddr  in  $clog2(PIXEL_HEIGHT)  pixel row within the visible region.
- addr_valid  in  1  xaddr/yaddr are in the visible region.
- text_addr  out  $clog2(COLS*ROWS)  text RAM address, with COLS=PIXEL_WIDTH/CHAR_W and ROWS=PIXEL_HEIGHT/CHAR_H.
- text_data  in  16  text RAM read data, 1-cycle synchronous read.
- font_addr  out  8+$clog2(CHAR_H)  font ROM address, {char, glyph_row}.
- font_data  in  8  font ROM read data, 1-cycle synchronous read; bit 7 is the leftmost pixel.
- cursor_en  in  1  cursor enable.
- cursor_col  in  $clog2(COLS)  cursor column.
- cursor_row  in  $clog2(ROWS)  cursor row.
- hsync  out  1  hsync_in delayed by LATENCY.
- vsync  out  1  vsync_in delayed by LATENCY.
- red, green, blue  out  4 each  pixel colour.

Behaviour:
- Reset values: all outputs 0, including text_addr, font_addr, hsync, vsync and RGB. All pipeline registers 0. Frame counter 0.
- Reset mid-frame clears the pipeline immediately. Outputs return to 0 the same edge and stay 0 until valid data propagates, LATENCY cycles after rst deasserts.
- Edge 1: register text_addr = (yaddr/CHAR_H)*COLS + xaddr/CHAR_W. Constant multiply; shifts only for the divisions.
  - Also register x%CHAR_W, y%CHAR_H, addr_valid and the cursor-hit flag.
  - Cursor hit: cursor_en & cell column == cursor_col & cell row == cursor_row.
- Edge 2: RAM samples text_addr.
- Edge 3: register font_addr = {text_data[7:0], y%CHAR_H} and latch the attribute fields of text_data.
- Edge 4: ROM samples font_addr.
- Edge 5: register RGB.
- LATENCY = 5 pxclk edges, from input sampling to RGB/hsync/vsync update. Sideband fields travel in a shift pipeline of equal depth.
- Text word fields:
  - [7:0] character code.
  - [11:8] fg palette index.
  - [14:12] bg palette index, 0-7.
  - [15] blink.
- Pixel bit = font_data[7 - x%CHAR_W].
- Blink phase = frame counter bit $clog2(BLINK_FRAMES). The frame counter increments on each rising edge of vsync_in and wraps freely.
- Pixel colour selection:
  - pixel bit 1 → fg colour, else bg colour.
  - If blink attribute = 1 and phase = 1 → force bg colour.
  - If cursor hit, glyph row >= CHAR_H-2 and phase = 0 → output fg colour regardless of glyph.
  - Cursor and blink evaluated simultaneously: the cursor wins.
- Palette: 16-entry 12-bit constant (CGA colours). bg uses entries 0-7.
- addr_valid = 0 at the pipeline tail → RGB = 0, regardless of memory data.
- text_addr and font_addr keep toggling during blanking: don't care, no side effects. There are no write ports.

Decomposition:
- vga_pkg holds:
  - text word field constants (CHAR_LSB, FG_LSB, BG_LSB, BLINK_BIT);
  - LATENCY = 5;
  - PALETTE: a 16x12-bit localparam array;
  - rgb_t: a packed struct of 4/4/4 bits.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH): sync-reset shift register used for hsync/vsync/valid and the sideband fields.

Test Plan:
- Reset: hold rst 3 cycles mid-line → all outputs 0 the edge after rst is sampled; first non-zero RGB no earlier than 5 cycles after release.
- Address mapping: xaddr=639, yaddr=479 valid → text_addr=2399 one edge later; with text_data=0x0F41 → font_addr={0x41,4'hF}.
- Pixel select: text_data=0x1F41, font_data=0x80 (glyph row holds 0x80) → pixel x%8=0 gives palette[15]=0xFFF; x%8=1 gives palette[1]=0x00A.
- Alignment: drive a hsync_in pulse and a valid span → hsync and first coloured pixel both appear exactly 5 cycles after input, no skew.
- Blink: blink bit set, 32 vsync_in pulses → glyph shows bg only; after 64 pulses the glyph is visible again.
- Cursor: cursor_en=1, col=3, row=2, phase 0 → pixels x=24..31, y=46..47 show fg; cursor_en=0 → normal glyph; addr_valid=0 → RGB=0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and types for the text-mode renderer
package vga_pkg;

    localparam int CHAR_LSB  = 0;
    localparam int FG_LSB    = 8;
    localparam int BG_LSB    = 12;
    localparam int BLINK_BIT = 15;
    localparam int LATENCY   = 5;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // CGA colours, 4 bits per channel
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - synchronously cleared fixed-depth shift register
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pxclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge pxclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_text_render.sv
// rtl/vga_text_render.sv - 80x30 text renderer: text RAM -> font ROM -> palette RGB
module vga_text_render
    import vga_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 640,
    parameter int PIXEL_HEIGHT = 480,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int BLINK_FRAMES = 32,
    localparam int COLS  = PIXEL_WIDTH / CHAR_W,
    localparam int ROWS  = PIXEL_HEIGHT / CHAR_H,
    localparam int XW    = $clog2(PIXEL_WIDTH),
    localparam int YW    = $clog2(PIXEL_HEIGHT),
    localparam int TA_W  = $clog2(COLS * ROWS),
    localparam int GW    = $clog2(CHAR_H),
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             pxclk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [XW-1:0]    xaddr,
    input  logic [YW-1:0]    yaddr,
    input  logic             addr_valid,
    output logic [TA_W-1:0]  text_addr,
    input  logic [15:0]      text_data,
    output logic [8+GW-1:0]  font_addr,
    input  logic [7:0]       font_data,
    input  logic             cursor_en,
    input  logic [COL_W-1:0] cursor_col,
    input  logic [ROW_W-1:0] cursor_row,
    output logic             hsync,
    output logic             vsync,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue
);

    localparam int CW     = $clog2(CHAR_W);
    localparam int FC_W   = $clog2(BLINK_FRAMES) + 1;
    localparam int SIDE_W = 2 + GW + CW;

    logic [COL_W-1:0]  cell_col;
    logic [ROW_W-1:0]  cell_row;
    logic              hit;
    logic [TA_W-1:0]   addr_next;
    logic [SIDE_W-1:0] side_in, side2, side4;
    logic [7:0]        attr3, attr4;
    logic [1:0]        sync_out;
    logic [FC_W-1:0]   frame_cnt;
    logic              vsync_prev;
    logic              phase;
    rgb_t              rgb_q, rgb_next;

    assign cell_col  = COL_W'(xaddr >> CW);
    assign cell_row  = ROW_W'(yaddr >> GW);
    assign hit       = cursor_en && (cell_col == cursor_col) && (cell_row == cursor_row);
    assign addr_next = TA_W'(cell_row) * TA_W'(COLS) + TA_W'(cell_col);
    assign side_in   = {addr_valid, hit, yaddr[GW-1:0], xaddr[CW-1:0]};

    always_ff @(posedge pxclk) begin
        if (rst) text_addr <= '0;
        else     text_addr <= addr_next;
    end

    // Sideband reaches font-address stage two edges after sampling, pixel stage four edges after
    vga_delay_line #(.WIDTH(SIDE_W), .DEPTH(2)) u_side_a (
        .pxclk(pxclk), .rst(rst), .din(side_in), .dout(side2)
    );

    vga_delay_line #(.WIDTH(SIDE_W), .DEPTH(2)) u_side_b (
        .pxclk(pxclk), .rst(rst), .din(side2), .dout(side4)
    );

    always_ff @(posedge pxclk) begin
        if (rst) begin
            font_addr <= '0;
            attr3     <= '0;
        end else begin
            font_addr <= {text_data[CHAR_LSB +: 8], side2[CW +: GW]};
            attr3     <= {text_data[BLINK_BIT], text_data[BG_LSB +: 3], text_data[FG_LSB +: 4]};
        end
    end

    vga_delay_line #(.WIDTH(8), .DEPTH(1)) u_attr (
        .pxclk(pxclk), .rst(rst), .din(attr3), .dout(attr4)
    );

    vga_delay_line #(.WIDTH(2), .DEPTH(LATENCY)) u_sync (
        .pxclk(pxclk), .rst(rst), .din({hsync_in, vsync_in}), .dout(sync_out)
    );

    always_ff @(posedge pxclk) begin
        if (rst) begin
            frame_cnt  <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign phase = frame_cnt[FC_W-1];

    // Cursor underline takes priority over blink suppression
    always_comb begin
        logic [11:0] fg_c, bg_c;
        logic        pix, cursor_on;
        rgb_next  = '0;
        fg_c      = PALETTE[attr4[3:0]];
        bg_c      = PALETTE[{1'b0, attr4[6:4]}];
        pix       = font_data[CW'(CHAR_W - 1) - side4[CW-1:0]];
        cursor_on = side4[CW+GW] && (side4[CW +: GW] >= GW'(CHAR_H - 2)) && !phase;
        if (side4[CW+GW+1]) begin
            if (cursor_on)               rgb_next = fg_c;
            else if (attr4[7] && phase)  rgb_next = bg_c;
            else if (pix)                rgb_next = fg_c;
            else                         rgb_next = bg_c;
        end
    end

    always_ff @(posedge pxclk) begin
        if (rst) rgb_q <= '0;
        else     rgb_q <= rgb_next;
    end

    assign hsync = sync_out[1];
    assign vsync = sync_out[0];
    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_text_render.sv
// tb/tb_vga_text_render.sv - self-checking bench for vga_text_render
module tb_vga_text_render;

    logic        pxclk = 1'b0;
    logic        rst;
    logic        hsync_in, vsync_in;
    logic [9:0]  xaddr;
    logic [8:0]  yaddr;
    logic        addr_valid;
    logic [11:0] text_addr;
    logic [15:0] text_data = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        hsync, vsync;
    logic [3:0]  red, green, blue;

    int n_tests = 0;
    int n_fail  = 0;
    int vs_count = 0;

    logic [15:0] tram [4096];
    logic [7:0]  fnt  [4096];

    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    typedef struct {
        int          x;
        int          y;
        bit          v;
        bit          cen;
        int          ccol;
        int          crow;
        logic [11:0] exp;
    } vec_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
    } exp_t;

    vec_t vecs [12];

    always #5 pxclk = ~pxclk;

    always @(posedge pxclk) begin
        text_data <= tram[text_addr];
        font_data <= fnt[font_addr];
    end

    vga_text_render dut (
        .pxclk(pxclk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .xaddr(xaddr), .yaddr(yaddr), .addr_valid(addr_valid),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    function automatic logic [11:0] model(int x, int y, bit v, bit cen, int ccol, int crow, bit ph);
        int col, row;
        logic [15:0] w;
        logic [7:0]  g;
        logic [11:0] fg, bg;
        if (!v) return 12'h000;
        col = x / 8;
        row = y / 16;
        w   = tram[row * 80 + col];
        g   = fnt[int'(w[7:0]) * 16 + y % 16];
        fg  = PAL[w[11:8]];
        bg  = PAL[w[14:12]];
        if (cen && col == ccol && row == crow && (y % 16) >= 14 && !ph) return fg;
        if (w[15] && ph) return bg;
        return g[7 - (x % 8)] ? fg : bg;
    endfunction

    function automatic bit cur_phase();
        return bit'((vs_count >> 5) & 1);
    endfunction

    function automatic logic [11:0] rgb();
        return {red, green, blue};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pxclk);
        #1;
    endtask

    task automatic set_px(input int x, input int y, input bit v);
        xaddr      = 10'(x);
        yaddr      = 9'(y);
        addr_valid = v;
    endtask

    task automatic pulse_vsync();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        vs_count++;
    endtask

    task automatic run_random(input int n);
        exp_t q[$];
        exp_t e;
        int   x, y;
        for (int i = 0; i < n; i++) begin
            if (i % 50 == 0) begin
                cursor_en  = 1'($urandom_range(0, 1));
                cursor_col = 7'($urandom_range(0, 79));
                cursor_row = 5'($urandom_range(0, 29));
            end
            if ($urandom_range(0, 3) == 0) begin
                x = int'(cursor_col) * 8 + int'($urandom_range(0, 7));
                y = int'(cursor_row) * 16 + int'($urandom_range(12, 15));
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            set_px(x, y, $urandom_range(0, 4) != 0);
            hsync_in = 1'($urandom_range(0, 1));
            e.rgb = model(x, y, addr_valid, cursor_en, int'(cursor_col), int'(cursor_row), cur_phase());
            e.hs  = hsync_in;
            q.push_back(e);
            tick();
            if (q.size() == 5) begin
                e = q.pop_front();
                chk("rand_rgb", 32'(rgb()), 32'(e.rgb));
                chk("rand_hsync", 32'(hsync), 32'(e.hs));
            end
        end
        hsync_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hsync_in = 0; vsync_in = 0;
        cursor_en = 0; cursor_col = 0; cursor_row = 0;
        set_px(0, 0, 0);
        for (int i = 0; i < 4096; i++) begin
            tram[i] = 16'($urandom);
            fnt[i]  = 8'($urandom);
        end
        tram[0]    = 16'h1F41;
        tram[5]    = 16'h9F41;
        tram[163]  = 16'h2141;
        tram[2399] = 16'h0F41;
        fnt[12'h410] = 8'h80;
        fnt[12'h41D] = 8'h00;
        fnt[12'h41E] = 8'h00;
        fnt[12'h41F] = 8'h01;

        vecs[0]  = '{0,   0,   1, 0, 0, 0, 12'hFFF};
        vecs[1]  = '{1,   0,   1, 0, 0, 0, 12'h00A};
        vecs[2]  = '{0,   0,   0, 0, 0, 0, 12'h000};
        vecs[3]  = '{639, 479, 1, 0, 0, 0, 12'hFFF};
        vecs[4]  = '{638, 479, 1, 0, 0, 0, 12'h000};
        vecs[5]  = '{24,  46,  1, 1, 3, 2, 12'h00A};
        vecs[6]  = '{30,  47,  1, 1, 3, 2, 12'h00A};
        vecs[7]  = '{24,  45,  1, 1, 3, 2, 12'h0A0};
        vecs[8]  = '{24,  46,  1, 0, 3, 2, 12'h0A0};
        vecs[9]  = '{24,  46,  1, 1, 4, 2, 12'h0A0};
        vecs[10] = '{24,  46,  0, 1, 3, 2, 12'h000};
        vecs[11] = '{40,  0,   1, 0, 0, 0, 12'hFFF};

        repeat (3) tick();
        chk("reset_rgb", 32'(rgb()), 0);
        chk("reset_hsync", 32'(hsync), 0);
        chk("reset_vsync", 32'(vsync), 0);
        chk("reset_text_addr", 32'(text_addr), 0);
        chk("reset_font_addr", 32'(font_addr), 0);
        rst = 1'b0;
        vs_count = 0;

        for (int i = 0; i < 16; i++) begin
            if (i < 12) begin
                set_px(vecs[i].x, vecs[i].y, vecs[i].v);
                cursor_en  = vecs[i].cen;
                cursor_col = 7'(vecs[i].ccol);
                cursor_row = 5'(vecs[i].crow);
            end else begin
                addr_valid = 1'b0;
            end
            tick();
            if (i >= 4) chk($sformatf("vec%0d", i - 4), 32'(rgb()), 32'(vecs[i-4].exp));
        end

        cursor_en = 0;
        set_px(639, 479, 1);
        tick();
        chk("text_addr_last", 32'(text_addr), 2399);
        tick();
        tick();
        chk("font_addr_last", 32'(font_addr), 32'h41F);

        set_px(0, 0, 0);
        repeat (6) tick();
        hsync_in = 1; vsync_in = 1;
        set_px(0, 0, 1);
        tick();
        hsync_in = 0; vsync_in = 0;
        vs_count++;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("align_hsync_t%0d", k), 32'(hsync), 0);
            chk($sformatf("align_rgb_t%0d", k), 32'(rgb()), 0);
            tick();
        end
        chk("align_hsync_t5", 32'(hsync), 1);
        chk("align_vsync_t5", 32'(vsync), 1);
        chk("align_rgb_t5", 32'(rgb()), 32'hFFF);
        tick();
        chk("align_hsync_t6", 32'(hsync), 0);

        run_random(400);

        while (vs_count < 32) pulse_vsync();
        cursor_en = 0;
        set_px(40, 0, 1);
        repeat (5) tick();
        chk("blink_hidden", 32'(rgb()), 32'h00A);
        set_px(0, 0, 1);
        repeat (5) tick();
        chk("noblink_phase1", 32'(rgb()), 32'hFFF);
        cursor_en = 1; cursor_col = 3; cursor_row = 2;
        set_px(24, 46, 1);
        repeat (5) tick();
        chk("cursor_phase1_off", 32'(rgb()), 32'h0A0);

        run_random(400);

        while (vs_count < 64) pulse_vsync();
        cursor_en = 0;
        set_px(40, 0, 1);
        repeat (5) tick();
        chk("blink_visible", 32'(rgb()), 32'hFFF);

        set_px(0, 0, 1);
        hsync_in = 1;
        repeat (5) tick();
        chk("pre_reset_rgb", 32'(rgb()), 32'hFFF);
        rst = 1'b1;
        tick();
        chk("midreset_rgb", 32'(rgb()), 0);
        chk("midreset_hsync", 32'(hsync), 0);
        chk("midreset_text_addr", 32'(text_addr), 0);
        chk("midreset_font_addr", 32'(font_addr), 0);
        tick();
        tick();
        rst = 1'b0;
        vs_count = 0;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("post_reset_rgb_t%0d", k), 32'(rgb()), 0);
            chk($sformatf("post_reset_hsync_t%0d", k), 32'(hsync), 0);
        end
        tick();
        chk("post_reset_rgb_t5", 32'(rgb()), 32'hFFF);
        chk("post_reset_hsync_t5", 32'(hsync), 1);
        hsync_in = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
